clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the half-period field and internal phase counter.
REQ-002 clk  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 en  input  1  SHALL request divided-clock generation (1 = run, 0 = stop at next period boundary).
REQ-005 cfg_valid  input  1  SHALL indicate a new half-period value is offered on cfg_half.
REQ-006 cfg_half  input  CNT_W  SHALL give the half-period H in clk cycles (output period = 2*H).
REQ-007 cfg_ready  output  1  SHALL indicate the block can accept a configuration this cycle.
REQ-008 clk_out  output  1  SHALL be the registered divided clock, 50% duty cycle.
REQ-009 tick  output  1  SHALL pulse for one cycle coincident with the first high cycle of every period.
REQ-010 busy  output  1  SHALL be 1 while in RUN state.
REQ-011 err  output  1  SHALL pulse for one cycle when a configuration with cfg_half = 0 is accepted.

Function
REQ-012 States SHALL be IDLE and RUN; registers: active_h, pending_h, pending_vld, phase (0 = high, 1 = low), cnt.
REQ-013 Handshake: transfer occurs on a cycle with cfg_valid = 1 and cfg_ready = 1; cfg_ready = !pending_vld.
REQ-014 Accepted cfg_half = 0 SHALL be discarded (no state change) and err = 1 on the following cycle.
REQ-015 In IDLE, an accepted non-zero value SHALL be written directly to active_h; pending_vld stays 0.
REQ-016 In RUN, an accepted non-zero value SHALL go to pending_h with pending_vld = 1.
REQ-017 IDLE: clk_out = 0, cnt = 0; if en = 1, next cycle SHALL enter RUN with clk_out = 1, tick = 1, cnt = 0, phase high, using active_h as updated on that same edge.
REQ-018 RUN: cnt increments each cycle; when cnt = active_h-1, cnt clears and phase toggles; clk_out SHALL stay 1 for exactly H cycles, then 0 for exactly H cycles.
REQ-019 Period boundary = last low cycle (phase low, cnt = active_h-1); pending_h SHALL be loaded into active_h only at a boundary, clearing pending_vld.
REQ-020 A configuration accepted on the boundary cycle itself SHALL take effect at the next boundary, not this one.
REQ-021 en SHALL be sampled only at the boundary: en = 0 -> IDLE (clk_out stays 0, no glitch); en = 1 -> next high phase begins with tick = 1.
REQ-022 en deasserted mid-period SHALL not truncate the period; en re-asserted before the boundary SHALL continue without interruption.
REQ-023 H = 1 SHALL yield clk_out = clk/2 with tick every 2 cycles; H = 2^CNT_W-1 SHALL work without counter overflow.

Reset
REQ-024 On rst: state IDLE, clk_out = 0, tick = 0, busy = 0, err = 0, cnt = 0, active_h = 2 (divide-by-4), pending_vld = 0, cfg_ready = 1.
REQ-025 rst asserted mid-period SHALL force clk_out = 0 the following cycle and discard any pending configuration.

Verification
REQ-026 Reset, en = 1, no cfg -> clk_out pattern 1100 repeating, tick every 4 cycles, busy = 1.
REQ-027 In IDLE write H = 3, then en = 1 -> 3 high, 3 low repeating; tick every 6 cycles.
REQ-028 Running H = 2, write H = 5 during high phase -> cfg_ready drops, current 1100 period completes, next period 5 high/5 low, cfg_ready returns to 1.
REQ-029 Write cfg_half = 0 -> err pulses once, period unchanged, cfg_ready stays 1.
REQ-030 Running H = 4, drop en in 2nd high cycle -> full 4 high/4 low completes, then IDLE, clk_out = 0, busy = 0; re-raise en -> restart with tick.
REQ-031 Assert rst mid-high with pending H = 7 -> clk_out = 0 next cycle; after release with en = 1, period is 1100 (H = 2).

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with a valid/ready configuration port.
// Half-period changes while running are staged and applied only at period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] active_h, active_h_n;
  logic [CNT_W-1:0] pending_h, pending_h_n;
  logic             pending_vld, pending_vld_n;
  logic             phase, phase_n;   // 0 = high half, 1 = low half
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             clk_out_n, tick_n, err_n;
  logic             accept, last;

  assign cfg_ready = !pending_vld;
  assign busy      = (state == RUN);
  assign accept    = cfg_valid && cfg_ready;
  // active_h is never zero, so active_h-1 cannot wrap.
  assign last      = (cnt == active_h - CNT_W'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n       = state;
    active_h_n    = active_h;
    pending_h_n   = pending_h;
    pending_vld_n = pending_vld;
    phase_n       = phase;
    cnt_n         = cnt;
    tick_n        = 1'b0;
    err_n         = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n   = '0;
        phase_n = 1'b0;
        if (en) begin
          state_n = RUN;
          tick_n  = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          cnt_n   = '0;
          phase_n = !phase;
          if (phase) begin
            // Period boundary: commit staged value and sample en.
            if (pending_vld) begin
              active_h_n    = pending_h;
              pending_vld_n = 1'b0;
            end
            if (en) tick_n  = 1'b1;
            else    state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A boundary load and an accept never coincide: accept requires pending_vld = 0.
    if (accept) begin
      if (cfg_half == '0) begin
        err_n = 1'b1;
      end else if (state == IDLE) begin
        active_h_n = cfg_half;
      end else begin
        pending_h_n   = cfg_half;
        pending_vld_n = 1'b1;
      end
    end

    clk_out_n = (state_n == RUN) && !phase_n;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_h    <= CNT_W'(2);
      pending_h   <= '0;
      pending_vld <= 1'b0;
      phase       <= 1'b0;
      cnt         <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      active_h    <= active_h_n;
      pending_h   <= pending_h_n;
      pending_vld <= pending_vld_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      clk_out     <= clk_out_n;
      tick        <= tick_n;
      err         <= err_n;
    end
  end

endmodule
